sample_ring_sram: RTL

- Synthesizable responder for the sample-ring memory interface.
- Serves the initiator side of the running-average datapath: read of the oldest sample, then write of the new one, at byte addresses stepping by 4 and wrapping at 252.
- Replaces the simulation-only SRAM wrapper with a fixed-latency, edge-triggered 64-word store.
- Self-clears after reset so the ring and the initiator's running total both start from zero.

---
 rtl/sample_ring_pkg.sv | 11 +
 rtl/ring_req_detect.sv | 47 ++++
 rtl/sample_ring_sram.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sample_ring_pkg.sv
// Types and ring geometry shared by the sample-ring SRAM responder and the
// running-average initiator.
package sample_ring_pkg;

  typedef enum logic [1:0] {CLEAR, IDLE, RD_WAIT, WR_WAIT} ring_state_e;

  localparam int RING_DEPTH     = 64;
  localparam int RING_LAST_ADDR = 252;
  localparam int RING_STRIDE    = 4;

endpackage

// File: rtl/ring_req_detect.sv
// Turns level enables into single requests and screens the byte address
// before the responder may accept anything.
module ring_req_detect
  import sample_ring_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = RING_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en_i,
  input  logic              wr_en_i,
  input  logic              idle_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              accept_rd_o,
  output logic              accept_wr_o,
  output logic              reject_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RING_STRIDE * DEPTH - RING_STRIDE);

  logic prev_rd_q;
  logic prev_wr_q;
  logic rise_rd;
  logic rise_wr;
  logic addr_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_rd_q <= 1'b0;
      prev_wr_q <= 1'b0;
    end else begin
      prev_rd_q <= rd_en_i;
      prev_wr_q <= wr_en_i;
    end
  end

  assign rise_rd = rd_en_i & ~prev_rd_q;
  assign rise_wr = wr_en_i & ~prev_wr_q;
  assign addr_ok = (addr_i[1:0] == 2'b00) && (addr_i <= LAST_ADDR);

  // On a simultaneous rise the write wins but the collision is still flagged.
  assign accept_wr_o = idle_i & rise_wr & addr_ok;
  assign accept_rd_o = idle_i & rise_rd & ~rise_wr & addr_ok;
  assign reject_o    = (rise_rd | rise_wr) & (~idle_i | ~addr_ok | (rise_rd & rise_wr));

endmodule

// File: rtl/sample_ring_sram.sv
// Fixed-latency 64-word store answering the running-average initiator; it
// zeroes itself after reset and on request.
module sample_ring_sram
  import sample_ring_pkg::*;
#(
  parameter int DEPTH   = RING_DEPTH,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_enable,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_clr,
  output logic [DATA_W-1:0] read_data,
  output logic              busy,
  output logic              req_error
);

  localparam int IDX_W = $clog2(DEPTH);
  // Wait edges left after acceptance before the completing edge.
  localparam logic [1:0] CNT_LOAD = 2'((LATENCY > 1) ? LATENCY - 2 : 0);

  ring_state_e       state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic              clr_pend_q, clr_pend_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept_rd, accept_wr, reject, accept;
  logic [IDX_W-1:0]  req_idx;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  ring_req_detect #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_detect (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (read_enable),
    .wr_en_i    (write_enable),
    .idle_i     ((state_q == IDLE) && !mem_clr),
    .addr_i     (address),
    .accept_rd_o(accept_rd),
    .accept_wr_o(accept_wr),
    .reject_o   (reject)
  );

  assign accept  = accept_rd | accept_wr;
  assign req_idx = address[IDX_W+1:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_idx_d  = clr_idx_q;
    clr_pend_d = clr_pend_q;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;
    mem_waddr  = clr_idx_q;
    mem_wdata  = '0;
    case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        if (mem_clr) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
          clr_idx_d = '0;
          state_d   = IDLE;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
      IDLE: begin
        if (mem_clr) begin
          clr_idx_d = '0;
          state_d   = CLEAR;
        end else if (accept && LATENCY == 1) begin
          mem_we    = accept_wr;
          mem_waddr = req_idx;
          mem_wdata = write_data;
          if (accept_rd) rdata_d = mem[req_idx];
        end else if (accept) begin
          cnt_d   = CNT_LOAD;
          state_d = accept_wr ? WR_WAIT : RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_clr) clr_pend_d = 1'b1;
        if (cnt_q == 2'd0) begin
          if (state_q == WR_WAIT) begin
            mem_we    = 1'b1;
            mem_waddr = idx_q;
            mem_wdata = wdata_q;
          end else begin
            rdata_d = mem[idx_q];
          end
          // A clear requested mid-access starts only after the access lands.
          if (clr_pend_q || mem_clr) begin
            clr_pend_d = 1'b0;
            clr_idx_d  = '0;
            state_d    = CLEAR;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      cnt_q      <= 2'd0;
      clr_idx_q  <= '0;
      clr_pend_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_idx_q  <= clr_idx_d;
      clr_pend_q <= clr_pend_d;
      rdata_q    <= rdata_d;
      err_q      <= reject;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= req_idx;
      wdata_q <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign read_data = rdata_q;
  assign busy      = (state_q != IDLE) && !rst;
  assign req_error = err_q;

endmodule
